// File: rtl/rv_core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_core_pkg
// Description : Shared integer-core constants and writeback entry type.
// Revision    : 1.0 - initial release
// ============================================================================
package rv_core_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_WIDTH-1:0] data;
    } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/wb_bypass_match.sv
`default_nettype none
// ============================================================================
// Module      : wb_bypass_match
// Description : Youngest-match search of the writeback queue for one read port.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_bypass_match #(
    parameter int DATA_WIDTH = rv_core_pkg::DATA_WIDTH,
    parameter int ADDR_W     = rv_core_pkg::REG_ADDR_W,
    parameter int DEPTH      = 4,
    parameter int PTR_W      = $clog2(DEPTH)
) (
    input  logic [ADDR_W-1:0]     rs,
    input  logic [PTR_W-1:0]      head,
    input  logic [DEPTH-1:0]      ent_valid,
    input  logic [ADDR_W-1:0]     ent_rd   [DEPTH],
    input  logic [DATA_WIDTH-1:0] ent_data [DEPTH],
    output logic                  hit,
    output logic [DATA_WIDTH-1:0] data
);

    logic [PTR_W-1:0] w_slot;

    // Walk oldest to youngest so the last match seen is the youngest.
    always_comb begin
        hit    = 1'b0;
        data   = '0;
        w_slot = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_slot = head + PTR_W'(k);
            if (ent_valid[w_slot] && (ent_rd[w_slot] == rs) && (rs != '0)) begin
                hit  = 1'b1;
                data = ent_data[w_slot];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_write_queue.sv
`default_nettype none
// ============================================================================
// Module      : wb_write_queue
// Description : In-order writeback queue feeding the RF write port, with
//               forwarding of pending results to the decode read ports.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_write_queue #(
    parameter int DATA_WIDTH = rv_core_pkg::DATA_WIDTH,
    parameter int ADDR_W     = rv_core_pkg::REG_ADDR_W,
    parameter int DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mem_valid,
    input  logic [ADDR_W-1:0]          mem_rd,
    input  logic [DATA_WIDTH-1:0]      mem_data,
    output logic                       mem_ready,
    input  logic                       alu_valid,
    input  logic [ADDR_W-1:0]          alu_rd,
    input  logic [DATA_WIDTH-1:0]      alu_data,
    output logic                       alu_ready,
    output logic                       rf_wen,
    output logic [ADDR_W-1:0]          rf_rd,
    output logic [DATA_WIDTH-1:0]      rf_wrdata,
    input  logic [ADDR_W-1:0]          byp_rs1,
    input  logic [ADDR_W-1:0]          byp_rs2,
    output logic                       byp_hit1,
    output logic [DATA_WIDTH-1:0]      byp_data1,
    output logic                       byp_hit2,
    output logic [DATA_WIDTH-1:0]      byp_data2,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W:0] c_DEPTH = (c_CNT_W + 1)'(DEPTH);

    logic [DEPTH-1:0]      r_valid;
    logic [ADDR_W-1:0]     r_rd   [DEPTH];
    logic [DATA_WIDTH-1:0] r_data [DEPTH];
    logic [c_PTR_W-1:0]    r_head;
    logic [c_PTR_W-1:0]    r_tail;
    logic [c_CNT_W-1:0]    r_count;

    logic                  w_pop;
    logic [c_CNT_W:0]      w_free;
    logic                  w_mem_push;
    logic                  w_alu_push;
    logic [1:0]            w_npush;
    logic [c_PTR_W-1:0]    w_alu_slot;

    assign w_pop  = (r_count != '0);
    // The head slot is released this edge, so it counts as free space.
    assign w_free = c_DEPTH - {1'b0, r_count} + {{c_CNT_W{1'b0}}, w_pop};

    assign mem_ready = (w_free >= (c_CNT_W + 1)'(1));
    assign alu_ready = mem_valid ? (w_free >= (c_CNT_W + 1)'(2))
                                 : (w_free >= (c_CNT_W + 1)'(1));

    // x0 results complete the handshake but are never stored.
    assign w_mem_push = mem_valid && mem_ready && (mem_rd != '0);
    assign w_alu_push = alu_valid && alu_ready && (alu_rd != '0);
    assign w_npush    = {1'b0, w_mem_push} + {1'b0, w_alu_push};
    assign w_alu_slot = r_tail + c_PTR_W'(w_mem_push);

    assign rf_wen    = w_pop;
    assign rf_rd     = w_pop ? r_rd[r_head]   : '0;
    assign rf_wrdata = w_pop ? r_data[r_head] : '0;
    assign count     = r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_rd[i]   <= '0;
                r_data[i] <= '0;
            end
        end else begin
            // Pop clears first so a push into the same slot (full queue) wins.
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + c_PTR_W'(1);
            end
            if (w_mem_push) begin
                r_valid[r_tail] <= 1'b1;
                r_rd[r_tail]    <= mem_rd;
                r_data[r_tail]  <= mem_data;
            end
            if (w_alu_push) begin
                r_valid[w_alu_slot] <= 1'b1;
                r_rd[w_alu_slot]    <= alu_rd;
                r_data[w_alu_slot]  <= alu_data;
            end
            r_tail  <= r_tail + c_PTR_W'(w_npush);
            r_count <= r_count + c_CNT_W'(w_npush) - c_CNT_W'(w_pop);
        end
    end

    wb_bypass_match #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_W     (ADDR_W),
        .DEPTH      (DEPTH),
        .PTR_W      (c_PTR_W)
    ) u_byp1 (
        .rs        (byp_rs1),
        .head      (r_head),
        .ent_valid (r_valid),
        .ent_rd    (r_rd),
        .ent_data  (r_data),
        .hit       (byp_hit1),
        .data      (byp_data1)
    );

    wb_bypass_match #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_W     (ADDR_W),
        .DEPTH      (DEPTH),
        .PTR_W      (c_PTR_W)
    ) u_byp2 (
        .rs        (byp_rs2),
        .head      (r_head),
        .ent_valid (r_valid),
        .ent_rd    (r_rd),
        .ent_data  (r_data),
        .hit       (byp_hit2),
        .data      (byp_data2)
    );

endmodule
`default_nettype wire

// File: tb/tb_wb_write_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_write_queue
// Description : Directed self-checking bench for wb_write_queue (DEPTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_write_queue;

    logic        clk;
    logic        rst;
    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        rf_wen;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wrdata;
    logic [4:0]  byp_rs1;
    logic [4:0]  byp_rs2;
    logic        byp_hit1;
    logic [31:0] byp_data1;
    logic        byp_hit2;
    logic [31:0] byp_data2;
    logic [2:0]  count;

    int n_pass;
    int n_total;

    logic [4:0]  m_rd[$];
    logic [31:0] m_data[$];

    wb_write_queue #(.DATA_WIDTH(32), .ADDR_W(5), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_valid (mem_valid),
        .mem_rd    (mem_rd),
        .mem_data  (mem_data),
        .mem_ready (mem_ready),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .alu_ready (alu_ready),
        .rf_wen    (rf_wen),
        .rf_rd     (rf_rd),
        .rf_wrdata (rf_wrdata),
        .byp_rs1   (byp_rs1),
        .byp_rs2   (byp_rs2),
        .byp_hit1  (byp_hit1),
        .byp_data1 (byp_data1),
        .byp_hit2  (byp_hit2),
        .byp_data2 (byp_data2),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One clock edge with the reference queue updated alongside, then compare.
    task automatic model_edge(input bit m_acc, input bit a_acc);
        @(posedge clk);
        if (m_rd.size() != 0) begin
            void'(m_rd.pop_front());
            void'(m_data.pop_front());
        end
        if (m_acc) begin m_rd.push_back(mem_rd); m_data.push_back(mem_data); end
        if (a_acc) begin m_rd.push_back(alu_rd); m_data.push_back(alu_data); end
        #1;
        check("q_count", count, m_rd.size());
        check("q_count_le_depth", count <= 3'd4, 1);
        check("q_wen", rf_wen, m_rd.size() != 0);
        check("q_rf_rd", rf_rd, (m_rd.size() != 0) ? m_rd[0] : 5'd0);
        check("q_rf_data", rf_wrdata, (m_data.size() != 0) ? m_data[0] : 32'd0);
    endtask

    initial begin
        int free;
        bit exp_alu;
        n_pass = 0; n_total = 0;
        rst = 1'b1;
        mem_valid = 0; mem_rd = 0; mem_data = 0;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        byp_rs1 = 0; byp_rs2 = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_wen", rf_wen, 0);
        check("rst_count", count, 0);
        check("rst_rf_rd", rf_rd, 0);
        check("rst_rf_data", rf_wrdata, 0);
        check("rst_hit1", byp_hit1, 0);
        check("rst_data2", byp_data2, 0);
        check("rst_mem_ready", mem_ready, 1);
        check("rst_alu_ready", alu_ready, 1);
        rst = 1'b0;
        step();

        // Single ALU push
        alu_valid = 1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF; byp_rs1 = 5'd5;
        #1;
        check("single_alu_ready", alu_ready, 1);
        step();
        alu_valid = 0;
        check("single_wen", rf_wen, 1);
        check("single_rd", rf_rd, 5);
        check("single_data", rf_wrdata, 32'hDEADBEEF);
        check("single_hit1", byp_hit1, 1);
        check("single_byp1", byp_data1, 32'hDEADBEEF);
        step();
        check("single_wen_after", rf_wen, 0);
        check("single_hit1_after", byp_hit1, 0);

        // Dual push to the same register: mem is older, ALU value forwarded
        mem_valid = 1; mem_rd = 5'd3; mem_data = 32'h11;
        alu_valid = 1; alu_rd = 5'd3; alu_data = 32'h22; byp_rs1 = 5'd3;
        #1;
        check("dual_alu_ready", alu_ready, 1);
        step();
        mem_valid = 0; alu_valid = 0;
        check("dual_count", count, 2);
        check("dual_wr1", rf_wrdata, 32'h11);
        check("dual_byp_a", byp_data1, 32'h22);
        check("dual_hit_a", byp_hit1, 1);
        step();
        check("dual_wr2", rf_wrdata, 32'h22);
        check("dual_wen2", rf_wen, 1);
        check("dual_byp_b", byp_data1, 32'h22);
        step();
        check("dual_drained", rf_wen, 0);
        check("dual_hit_c", byp_hit1, 0);

        // rd = 0 push is handshaken but dropped
        alu_valid = 1; alu_rd = 5'd0; alu_data = 32'h55; byp_rs1 = 5'd0;
        #1;
        check("x0_ready", alu_ready, 1);
        step();
        alu_valid = 0;
        check("x0_count", count, 0);
        check("x0_wen", rf_wen, 0);
        check("x0_hit1", byp_hit1, 0);

        // Youngest match wins on port 2
        mem_valid = 1; mem_rd = 5'd7; mem_data = 32'hA;
        alu_valid = 1; alu_rd = 5'd7; alu_data = 32'hB;
        byp_rs1 = 5'd9; byp_rs2 = 5'd7;
        step();
        mem_valid = 0; alu_valid = 0;
        check("byp_hit2", byp_hit2, 1);
        check("byp_data2_young", byp_data2, 32'hB);
        check("byp_miss1", byp_hit1, 0);
        step();
        check("byp_hit2_b", byp_hit2, 1);
        check("byp_data2_b", byp_data2, 32'hB);
        step();
        check("byp_hit2_gone", byp_hit2, 0);
        check("byp_data2_zero", byp_data2, 0);

        // Distinct registers on the two ports
        mem_valid = 1; mem_rd = 5'd8; mem_data = 32'hC;
        alu_valid = 1; alu_rd = 5'd9; alu_data = 32'hD;
        byp_rs1 = 5'd8; byp_rs2 = 5'd9;
        step();
        mem_valid = 0; alu_valid = 0;
        check("byp_port1_8", byp_data1, 32'hC);
        check("byp_port2_9", byp_data2, 32'hD);
        repeat (2) step();
        check("byp_pair_drained", count, 0);

        // Fill with both producers valid every cycle
        for (int cyc = 0; cyc < 12; cyc++) begin
            mem_valid = 1; mem_rd = 5'(1 + (cyc % 15)); mem_data = 32'h1000 + cyc;
            alu_valid = 1; alu_rd = 5'(16 + (cyc % 15)); alu_data = 32'h2000 + cyc;
            #1;
            free = 4 - m_rd.size() + ((m_rd.size() != 0) ? 1 : 0);
            exp_alu = (free >= 2);
            check("fill_mem_ready", mem_ready, 1);
            check("fill_alu_ready", alu_ready, exp_alu);
            model_edge(1'b1, exp_alu);
        end
        mem_valid = 0; alu_valid = 0;
        for (int cyc = 0; cyc < 6; cyc++) model_edge(1'b0, 1'b0);
        check("fill_all_drained", count, 0);

        // Reset mid-traffic with three entries queued
        mem_valid = 1; mem_rd = 5'd10; mem_data = 32'h31;
        alu_valid = 1; alu_rd = 5'd11; alu_data = 32'h32;
        step();
        mem_rd = 5'd12; mem_data = 32'h33;
        alu_rd = 5'd13; alu_data = 32'h34;
        byp_rs1 = 5'd12;
        step();
        mem_valid = 0; alu_valid = 0;
        check("pre_rst_count", count, 3);
        #3;
        rst = 1'b1;
        #1;
        check("mid_rst_wen", rf_wen, 0);
        check("mid_rst_count", count, 0);
        check("mid_rst_hit1", byp_hit1, 0);
        repeat (2) step();
        rst = 1'b0;
        for (int cyc = 0; cyc < 3; cyc++) begin
            step();
            check("post_rst_wen", rf_wen, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
